// File: rtl/falcon_ntt_ctrl.sv
// falcon_ntt_ctrl
// Sequencer for the Falcon single-butterfly NTT datapath (q = 12289).
// Runs a forward NTT (Cooley-Tukey), inverse NTT (Gentleman-Sande) or
// point-wise multiply pass over a coefficient memory of N = 2^logn words.
// Each ISSUE cycle presents one butterfly's read addresses and twiddle
// address.  The matching write-back addresses come out of a D-deep shift
// line.  A DRAIN of D cycles between stages keeps a stage from reading
// words that the previous stage has not yet written.
//
// Optional feature macro: FALCON_PWM_EN
//   defined   : mode 2'b10 runs the point-wise multiply pass
//   undefined : mode 2'b10 is rejected with err, bf_pwm is tied 0
//
// Ports
//   clk, rst_n           clock (rising edge), async active-low reset
//   start, mode, logn    run request; sampled only while idle
//   busy, done, err      run status; done and err are one-cycle pulses
//   rd_en, rd_addr_a/b   issue strobe and coefficient read addresses
//   tw_addr, tw_inv      twiddle-ROM address and inverse-table select
//   bf_ct, bf_pwm        butterfly mode controls, held while busy
//   wr_en, wr_addr_a/b   write-back strobe and addresses (E and O)
module falcon_ntt_ctrl #(
  parameter int LOGN   = 10,
  parameter int RD_LAT = 1,
  parameter int CT_LAT = 4,
  parameter int GS_LAT = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [1:0]      mode,
  input  logic [3:0]      logn,
  output logic            busy,
  output logic            done,
  output logic            err,
  output logic            rd_en,
  output logic [LOGN-1:0] rd_addr_a,
  output logic [LOGN-1:0] rd_addr_b,
  output logic [LOGN-1:0] tw_addr,
  output logic            tw_inv,
  output logic            bf_ct,
  output logic            bf_pwm,
  output logic            wr_en,
  output logic [LOGN-1:0] wr_addr_a,
  output logic [LOGN-1:0] wr_addr_b
);

  localparam int DMAX = RD_LAT + ((CT_LAT > GS_LAT) ? CT_LAT : GS_LAT);
  localparam int DCW  = $clog2(DMAX + 1);
  localparam int AW   = $clog2(DMAX);
`ifdef FALCON_PWM_EN
  localparam int CW = LOGN;      // PWM walks all N coefficients
`else
  localparam int CW = LOGN - 1;  // transforms only need N/2 issues
`endif
  localparam logic [LOGN-1:0] ONE = LOGN'(1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_e;

  state_e         state_q, state_d;
  logic [1:0]     mode_q, mode_d;
  logic [3:0]     logn_q, logn_d;
  logic [3:0]     stage_q, stage_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [DCW-1:0] dcnt_q, dcnt_d;
  logic           err_q, err_d;

  logic            is_intt, is_pwm, mode_ok, logn_ok, last_issue;
  logic [DCW-1:0]  d_len;
  logic [AW-1:0]   tap;
  logic [3:0]      sh;
  logic [LOGN-1:0] cnt_ext, len, grp, a_addr, b_addr, tw, last_cnt;

  assign is_intt = (mode_q == 2'b01);
`ifdef FALCON_PWM_EN
  assign is_pwm  = (mode_q == 2'b10);
  assign mode_ok = (mode != 2'b11);
`else
  assign is_pwm  = 1'b0;
  assign mode_ok = ~mode[1];
`endif
  assign logn_ok = (logn != 4'd0) && (logn <= 4'(LOGN));
  assign d_len   = is_intt ? DCW'(RD_LAT + GS_LAT) : DCW'(RD_LAT + CT_LAT);
  assign tap     = AW'(d_len - DCW'(1));

  // sh = logn-1-s: log2 of the NTT half-span, and of the INTT twiddle base.
  assign sh      = logn_q - stage_q - 4'd1;
  assign cnt_ext = LOGN'(cnt_q);

  always_comb begin
    len    = '0;
    grp    = '0;
    a_addr = cnt_ext;
    b_addr = cnt_ext;
    tw     = cnt_ext;
    if (!is_pwm) begin
      if (is_intt) begin
        len = ONE << stage_q;
        grp = cnt_ext >> stage_q;
        tw  = (ONE << sh) + grp;
      end else begin
        len = ONE << sh;
        grp = cnt_ext >> sh;
        tw  = (ONE << stage_q) + grp;
      end
      // len is a power of two, so the group offset and j never overlap.
      a_addr = (grp << (4'd1 + ((is_intt) ? stage_q : sh))) | (cnt_ext & (len - ONE));
      b_addr = a_addr + len;
    end
  end

  assign last_cnt   = is_pwm ? ((ONE << logn_q) - ONE) : ((ONE << (logn_q - 4'd1)) - ONE);
  assign last_issue = (cnt_ext == last_cnt);

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    logn_d  = logn_q;
    stage_d = stage_q;
    cnt_d   = cnt_q;
    dcnt_d  = dcnt_q;
    err_d   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          if (mode_ok && logn_ok) begin
            state_d = S_ISSUE;
            mode_d  = mode;
            logn_d  = logn;
            stage_d = 4'd0;
            cnt_d   = '0;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_ISSUE: begin
        cnt_d = cnt_q + CW'(1);
        if (last_issue) begin
          state_d = S_DRAIN;
          dcnt_d  = '0;
        end
      end
      S_DRAIN: begin
        dcnt_d = dcnt_q + DCW'(1);
        if (dcnt_q == d_len - DCW'(1)) begin
          if (is_pwm || (stage_q == logn_q - 4'd1)) begin
            state_d = S_DONE;
          end else begin
            state_d = S_ISSUE;
            stage_d = stage_q + 4'd1;
            cnt_d   = '0;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      mode_q  <= 2'b00;
      logn_q  <= 4'd0;
      stage_q <= 4'd0;
      cnt_q   <= '0;
      dcnt_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      logn_q  <= logn_d;
      stage_q <= stage_d;
      cnt_q   <= cnt_d;
      dcnt_q  <= dcnt_d;
      err_q   <= err_d;
    end
  end

  assign rd_en     = (state_q == S_ISSUE);
  assign busy      = (state_q == S_ISSUE) || (state_q == S_DRAIN);
  assign done      = (state_q == S_DONE);
  assign err       = err_q;
  assign rd_addr_a = rd_en ? a_addr : '0;
  assign rd_addr_b = rd_en ? b_addr : '0;
  assign tw_addr   = rd_en ? tw : '0;
  assign tw_inv    = busy && is_intt;
  assign bf_ct     = busy && !is_intt && !is_pwm;
`ifdef FALCON_PWM_EN
  assign bf_pwm    = busy && is_pwm;
`else
  assign bf_pwm    = 1'b0;
`endif

  // Write-back line: sized for the longer latency, tapped at D-1 so the
  // write strobe trails its issue by exactly D cycles in every mode.
  logic            line_vld_q [DMAX];
  logic [LOGN-1:0] line_a_q   [DMAX];
  logic [LOGN-1:0] line_b_q   [DMAX];

  generate
    for (genvar gi = 0; gi < DMAX; gi++) begin : g_line
      if (gi == 0) begin : g_head
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) begin
            line_vld_q[0] <= 1'b0;
            line_a_q[0]   <= '0;
            line_b_q[0]   <= '0;
          end else begin
            line_vld_q[0] <= rd_en;
            line_a_q[0]   <= rd_addr_a;
            line_b_q[0]   <= rd_addr_b;
          end
        end
      end else begin : g_body
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) begin
            line_vld_q[gi] <= 1'b0;
            line_a_q[gi]   <= '0;
            line_b_q[gi]   <= '0;
          end else begin
            line_vld_q[gi] <= line_vld_q[gi-1];
            line_a_q[gi]   <= line_a_q[gi-1];
            line_b_q[gi]   <= line_b_q[gi-1];
          end
        end
      end
    end
  endgenerate

  assign wr_en     = line_vld_q[tap];
  assign wr_addr_a = wr_en ? line_a_q[tap] : '0;
  assign wr_addr_b = wr_en ? line_b_q[tap] : '0;

endmodule

// File: doc/falcon_ntt_ctrl.md
# falcon_ntt_ctrl

Sequencer for the Falcon single-butterfly NTT datapath (q = 12289, N ≤ 1024). On a start command it runs a complete forward NTT (CT), inverse NTT (GS) or point-wise multiply pass over a coefficient memory. Each cycle it issues read addresses, the twiddle-ROM address and butterfly mode controls. It generates the matching write-back addresses delayed by the memory-plus-butterfly latency, and inserts pipeline drain between stages to avoid read-after-write hazards.

## Interface
- LOGN, 10: log2 of maximum polynomial length.
- RD_LAT, 1: coefficient-memory and twiddle-ROM read latency, cycles.
- CT_LAT, 4: butterfly latency from A/B/W inputs to E/O outputs, CT and PWM modes.
- GS_LAT, 5: butterfly latency from A/B/W inputs to E/O outputs, GS mode.
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- mode  in  2  00 NTT, 01 INTT, 10 PWM, 11 illegal; sampled with start.
- logn  in  4  run size, N = 2^logn, legal range 1..LOGN; sampled with start.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle completion pulse.
- err  out  1  one-cycle pulse on a rejected start.
- rd_en  out  1  read/issue strobe.
- rd_addr_a, rd_addr_b  out  LOGN  coefficient read addresses.
- tw_addr  out  LOGN  twiddle-ROM address.
- tw_inv  out  1  selects the inverse twiddle table.
- bf_ct, bf_pwm  out  1  butterfly CT and PWM controls, held for the whole run.
- wr_en  out  1  write-back strobe.
- wr_addr_a, wr_addr_b  out  LOGN  write addresses for E and O.

## Operation
- States: IDLE, ISSUE, DRAIN, DONE.
- IDLE:
  - A start with a legal mode and logn goes to ISSUE, with stage s=0 and counter c=0.
  - A start with logn=0, logn>LOGN or mode=11 pulses err the next cycle and stays in IDLE.
- Define D = RD_LAT + CT_LAT for NTT and PWM, and D = RD_LAT + GS_LAT for INTT.
- ISSUE asserts rd_en every cycle.
  - NTT, stage s: len = N>>(s+1), g = c>>(logn-1-s), j = c&(len-1).
    - a = g·2len + j, b = a + len, tw_addr = (1<<s) + g, tw_inv=0.
    - N/2 issues per stage, logn stages.
  - INTT, stage s: len = 1<<s, g = c>>s, j = c&(len-1).
    - a = g·2len + j, b = a + len, tw_addr = (N>>(s+1)) + g, tw_inv=1.
    - N/2 issues per stage, logn stages.
  - PWM: a = b = c, tw_addr = c (second operand via the W port), N issues in a single stage.
- After the last issue of a stage, go to DRAIN for D cycles, then either:
  - next stage: ISSUE with c=0 and s+1, or
  - last stage: DONE.
- Write-back: a D-deep shift line carries {valid, a, b}.
  - wr_en and wr_addr_a/b appear exactly D cycles after the matching rd_en.
  - In PWM only wr_addr_a is meaningful; wr_addr_b = wr_addr_a.
- DONE: done pulses for one cycle, busy drops the same cycle, return to IDLE.
- A start while busy is ignored: no err, no effect.
- Address arithmetic is in LOGN bits; bits above logn are 0.

## Timing
- Reset value of all outputs is 0; state resets to IDLE and the shift line is cleared.
- Reset mid-run aborts immediately. No wr_en pulse emerges after rst_n is released.
- Start accepted at cycle t:
  - busy=1 and the first rd_en at t+1.
  - The last issue of a stage at cycle L is followed by the next stage's first issue at L+D+1.
  - done at cycle L_final + D + 1.
- Total run cycles from t+1 to done inclusive:
  - NTT/INTT: logn·(N/2 + D) + 1.
  - PWM: N + D + 1.
- A new start is accepted in the cycle after done.

## Configuration
- FALCON_PWM_EN:
  - Defined: mode 10 runs the PWM pass.
  - Undefined: mode 10 is illegal (err pulse, no run), bf_pwm is tied 0, and the PWM counter width is not built.

## Test plan
- NTT, logn=2, RD_LAT=1, CT_LAT=4 (D=5): issues (a,b,tw) = (0,2,1),(1,3,1); then 5 drain cycles; then (0,1,2),(2,3,3). wr_en mirrors each issue 5 cycles later; done at cycle 15 after start.
- INTT, logn=2, GS_LAT=5 (D=6): issues (0,1,2),(2,3,3); then (0,2,1),(1,3,1). tw_inv=1, bf_ct=0 throughout; done 17 cycles after start.
- PWM, logn=3, macro defined: 8 issues with addresses 0..7, bf_pwm=1, wr_addr_a 0..7 delayed 5 cycles; done 14 cycles after start. With the macro undefined: err pulse, busy stays 0.
- Illegal starts: logn=0, logn=11, mode=11 each give one err pulse and no rd_en. A start pulsed mid-run is ignored and the cycle count is unchanged.
- rst_n low during stage 1 of a logn=10 NTT: all outputs 0 immediately, no wr_en after release, and a fresh start runs normally.
- Full-size NTT, logn=10: 5120 issues; each coefficient index is written exactly once per stage; done at 10·(512+5)+1 cycles.
